// File: rtl/nn_result_reader.sv
// nn_result_reader
//   Output-side consumer of the two-layer network. When the network pulses
//   scores_valid, all NUM_CLASSES signed scores are captured in one cycle.
//   A sequential argmax scan then compares one class per cycle. The winning
//   index and score are published. After that, every captured score is
//   streamed out for logging or host readback.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rstn         asynchronous active-low reset, clears every register
//   scores_valid one-cycle pulse, network outputs are final (used only in IDLE)
//   scores       packed signed scores, class k in [k*SCORE_BITS +: SCORE_BITS]
//   busy         high in SCAN and EMIT
//   class_valid  high from argmax completion until the next accepted frame
//   class_idx    winning class index
//   class_score  winning signed score
//   out_valid    stream word valid
//   out_ready    downstream ready
//   out_data     streamed score, bit-exact copy of the captured value
//   out_idx      class index of out_data
//   out_last     marks the word for class NUM_CLASSES-1
//
// Stream handshake: a word transfers on every rising edge where out_valid
// and out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_idx/out_last hold steady. out_valid never drops without a
// transfer; the only exception is reset.
module nn_result_reader #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_BITS  = 48,
  parameter int IDX_BITS    = 4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              scores_valid,
  input  logic [NUM_CLASSES*SCORE_BITS-1:0] scores,
  output logic                              busy,
  output logic                              class_valid,
  output logic [IDX_BITS-1:0]               class_idx,
  output logic [SCORE_BITS-1:0]             class_score,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SCORE_BITS-1:0]             out_data,
  output logic [IDX_BITS-1:0]               out_idx,
  output logic                              out_last
);

  // The scan pointer must reach NUM_CLASSES. That final value marks the
  // extra cycle in which the result is published, which gives the
  // NUM_CLASSES-cycle latency from the capture edge.
  localparam int PTR_W = $clog2(NUM_CLASSES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, EMIT = 2'd2} state_t;

  state_t                        state, state_nxt;
  logic signed [SCORE_BITS-1:0]  cap [NUM_CLASSES];
  logic signed [SCORE_BITS-1:0]  best;
  logic        [IDX_BITS-1:0]    best_idx;
  logic        [PTR_W-1:0]       ptr;
  logic signed [SCORE_BITS-1:0]  scan_cur;
  logic        [IDX_BITS-1:0]    emit_nxt_idx;
  logic signed [SCORE_BITS-1:0]  emit_nxt;
  logic                          scan_done;
  logic                          xfer;

  assign scan_done    = (ptr == PTR_W'(NUM_CLASSES));
  assign xfer         = out_valid && out_ready;
  assign emit_nxt_idx = out_idx + 1'b1;

  // Captured-score selection for the scan compare and the next stream word.
  always_comb begin
    scan_cur = cap[0];
    emit_nxt = cap[0];
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (ptr == PTR_W'(k))             scan_cur = cap[k];
      if (emit_nxt_idx == IDX_BITS'(k)) emit_nxt = cap[k];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scores_valid)       state_nxt = SCAN;
      SCAN:    if (scan_done)          state_nxt = EMIT;
      EMIT:    if (xfer && out_last)   state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == SCAN) || (state == EMIT);
  end

  // Datapath: capture, scan and stream registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_CLASSES; k++) cap[k] <= '0;
      best        <= '0;
      best_idx    <= '0;
      ptr         <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
      class_score <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_idx     <= '0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scores_valid) begin
            for (int k = 0; k < NUM_CLASSES; k++)
              cap[k] <= scores[k*SCORE_BITS +: SCORE_BITS];
            best        <= scores[0 +: SCORE_BITS];
            best_idx    <= '0;
            ptr         <= PTR_W'(1);
            class_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (scan_done) begin
            class_idx   <= best_idx;
            class_score <= best;
            class_valid <= 1'b1;
            out_valid   <= 1'b1;
            out_data    <= cap[0];
            out_idx     <= '0;
            out_last    <= 1'b0;  // NUM_CLASSES >= 2, so word 0 is never last
          end else begin
            // Strict greater-than: ties keep the lower index.
            if (scan_cur > best) begin
              best     <= scan_cur;
              best_idx <= IDX_BITS'(ptr);
            end
            ptr <= ptr + 1'b1;
          end
        end
        EMIT: begin
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_idx  <= emit_nxt_idx;
              out_data <= emit_nxt;
              out_last <= (emit_nxt_idx == IDX_BITS'(NUM_CLASSES - 1));
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_result_reader.sv
module tb_nn_result_reader;

  localparam int N  = 10;
  localparam int W  = 48;
  localparam int IB = 4;
  localparam int SW = W + IB + 1;  // stream word: {data, idx, last}
  localparam int CW = IB + W;      // class result: {idx, score}

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           scores_valid = 1'b0;
  logic [N*W-1:0] scores = '0;
  logic           busy;
  logic           class_valid;
  logic [IB-1:0]  class_idx;
  logic [W-1:0]   class_score;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [IB-1:0]  out_idx;
  logic           out_last;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  nn_result_reader #(.NUM_CLASSES(N), .SCORE_BITS(W), .IDX_BITS(IB)) dut (
    .clk(clk), .rstn(rstn), .scores_valid(scores_valid), .scores(scores),
    .busy(busy), .class_valid(class_valid), .class_idx(class_idx),
    .class_score(class_score), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  // ready driver: 0 = always ready, 1 = random 50%, 2 = held low
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    if (!rstn)               out_ready = 1'b0;
    else if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                      out_ready = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [SW-1:0] exp_q[$];
  logic [CW-1:0] cls_q[$];
  int            cyc_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  logic signed [W-1:0] sc [N];

  // Call between clock edges; the following rising edge samples the pulse.
  task automatic pulse(input bit accept, input logic [IB-1:0] ei, input logic signed [W-1:0] es);
    for (int k = 0; k < N; k++) scores[k*W +: W] = sc[k];
    scores_valid = 1'b1;
    if (accept) begin
      cls_q.push_back({ei, es});
      for (int k = 0; k < N; k++) exp_q.push_back({sc[k], IB'(k), (k == N - 1)});
    end
    @(posedge clk);
    #1;
    if (accept) cyc_q.push_back(cyc);
    scores_valid = 1'b0;
    scores = '0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge clk);
    while (busy && n < lim) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_emit(input int lim);
    int n = 0;
    @(negedge clk);
    while (!(class_valid && busy) && n < lim) begin @(negedge clk); n++; end
    check("emit_timeout", class_valid && busy, 1);
  endtask

  task automatic check_queues_empty(input string name);
    check({name, "_stream_q"}, exp_q.size(), 0);
    check({name, "_class_q"}, cls_q.size(), 0);
  endtask

  task automatic load_basic();
    for (int k = 0; k < N; k++) sc[k] = W'(7);
    sc[0] = -48'sd5; sc[1] = 48'sd3; sc[2] = 48'sd100;
  endtask

  // ---------------- monitor ----------------
  logic          prev_cv = 1'b0;
  logic          held_v  = 1'b0;
  logic [SW-1:0] held_w  = '0;

  always @(negedge clk) begin
    logic [SW-1:0] w;
    logic [CW-1:0] c;
    int            c0;
    w = {out_data, out_idx, out_last};
    if (rstn) begin
      if (class_valid && !prev_cv) begin
        if (cls_q.size() == 0) check("class_unexpected", 1, 0);
        else begin
          c  = cls_q.pop_front();
          c0 = cyc_q.pop_front();
          check("class_idx", class_idx, c[CW-1 -: IB]);
          check("class_score", class_score, c[W-1:0]);
          check("class_latency", cyc - c0, N);
        end
      end
      if (held_v && out_valid) check("stall_stable", w, held_w);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("word_unexpected", w, 0);
        else check("stream_word", w, exp_q.pop_front());
      end
      held_v = out_valid && !out_ready;
      held_w = w;
    end else begin
      held_v = 1'b0;
    end
    prev_cv = class_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset / idle
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_outputs",
            {busy, class_valid, class_idx, class_score, out_valid, out_data, out_idx, out_last}, 0);
    end

    // Basic argmax, always ready
    ready_mode = 0;
    load_basic();
    pulse(1, 4'd2, 48'sd100);
    wait_idle(100);
    check_queues_empty("basic");

    // All equal: tie keeps index 0
    for (int k = 0; k < N; k++) sc[k] = -48'sd1;
    @(negedge clk);
    pulse(1, 4'd0, -48'sd1);
    wait_idle(100);

    // All negative, signed compare
    for (int k = 0; k < N; k++) sc[k] = -48'sd1000;
    sc[6] = -48'sd2;
    @(negedge clk);
    pulse(1, 4'd6, -48'sd2);
    wait_idle(100);
    check_queues_empty("signed");

    // Full-range extremes, winner at the last class, under backpressure
    for (int k = 0; k < N; k++) sc[k] = W'(k * 1000 - 5000);
    sc[0] = 48'sh8000_0000_0000;
    sc[9] = 48'sh7FFF_FFFF_FFFF;
    ready_mode = 2;
    @(negedge clk);
    pulse(1, 4'd9, 48'sh7FFF_FFFF_FFFF);
    repeat (20) @(negedge clk);
    ready_mode = 1;
    wait_idle(2000);
    check_queues_empty("backpressure");

    // Random backpressure on the basic frame as well
    load_basic();
    @(negedge clk);
    pulse(1, 4'd2, 48'sd100);
    wait_idle(2000);
    ready_mode = 0;
    check_queues_empty("backpressure2");

    // Ignored restart during SCAN and EMIT
    load_basic();
    @(negedge clk);
    pulse(1, 4'd2, 48'sd100);
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) sc[k] = 48'sd500;
    pulse(0, 4'd0, 48'sd0);
    wait_emit(50);
    pulse(0, 4'd0, 48'sd0);
    wait_idle(100);
    // Next frame accepted on the first IDLE cycle
    for (int k = 0; k < N; k++) sc[k] = -48'sd1000;
    sc[6] = -48'sd2;
    pulse(1, 4'd6, -48'sd2);
    @(negedge clk);
    check("restart_cv_clear", class_valid, 0);
    check("restart_busy", busy, 1);
    wait_idle(100);
    check_queues_empty("restart");

    // Reset mid-EMIT at idx 4
    load_basic();
    @(negedge clk);
    pulse(1, 4'd2, 48'sd100);
    begin
      int n = 0;
      @(negedge clk);
      while (!(out_valid && out_idx == 4'd4) && n < 100) begin @(negedge clk); n++; end
      check("reach_idx4", out_valid && out_idx == 4'd4, 1);
    end
    #2 rstn = 1'b0;
    #1 check("async_reset_outputs",
             {busy, class_valid, class_idx, class_score, out_valid, out_data, out_idx, out_last}, 0);
    exp_q.delete();
    check("reset_class_q", cls_q.size(), 0);
    cls_q.delete();
    cyc_q.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    pulse(1, 4'd2, 48'sd100);
    wait_idle(100);
    check_queues_empty("after_reset");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard against hangs
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
